flash_cache_arbiter: RTL and testbench

Shares the single-page flash cache between two read requesters: the core fetch/data port and the Wishbone slave port. It arbitrates round-robin, serves hits from the page SRAM and, when automatic page selection is enabled, sequences page reloads through the SPI flash page loader on a miss. It sits between the flash controller's register block, its page-buffer SRAM and the QSPI loader.

---
 rtl/flash_cache_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_flash_cache_arbiter.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cache_arbiter.sv
// flash_cache_arbiter
// Shares the single-page flash cache between the core read port and the
// Wishbone read port. Requests are granted round-robin on ties. Hits are
// served from the page SRAM. Misses either reload the page through the QSPI
// loader (automatic page selection) or fail with an error response.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   flash_enable, auto_page   FLASH_CONFIG[0], FLASH_CONFIG[1]
//   page_wr, page_wr_data     write strobe/data for FLASH_CURRENT_PAGE_ADDRESS
//   core_req/addr/ack/err/data  core read port (req/addr held until ack)
//   wb_req/addr/ack/err/data    Wishbone read port (same protocol)
//   cache_addr, cache_rdata   page-SRAM word address / read data (1-cycle latency)
//   load_start, load_page, load_done  page loader handshake
//   current_page, page_valid  page held in the SRAM and whether it is loaded
//   busy                      high while not IDLE (FLASH_STATUS[0])
module flash_cache_arbiter #(
    parameter  int unsigned ADDR_WIDTH = 24,
    parameter  int unsigned PAGE_WORDS = 512,
    localparam int unsigned WORD_W     = $clog2(PAGE_WORDS),
    localparam int unsigned PAGE_W     = ADDR_WIDTH - WORD_W - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flash_enable,
    input  logic                  auto_page,
    input  logic                  page_wr,
    input  logic [PAGE_W-1:0]     page_wr_data,
    input  logic                  core_req,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    output logic                  core_ack,
    output logic                  core_err,
    output logic [31:0]           core_data,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic [31:0]           wb_data,
    output logic [WORD_W-1:0]     cache_addr,
    input  logic [31:0]           cache_rdata,
    output logic                  load_start,
    output logic [PAGE_W-1:0]     load_page,
    input  logic                  load_done,
    output logic [PAGE_W-1:0]     current_page,
    output logic                  page_valid,
    output logic                  busy
);

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_WB   = 1'b1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_START = 3'd1,
        LOAD_WAIT  = 3'd2,
        READ       = 3'd3,
        RESPOND    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                resp_err_q, resp_err_d;
    logic                manual_q, manual_d;
    logic                pend_q, pend_d;
    logic [PAGE_W-1:0]   pend_data_q, pend_data_d;
    logic [WORD_W-1:0]   req_word_q, req_word_d;
    logic [PAGE_W-1:0]   cur_page_q, cur_page_d;
    logic                page_valid_q, page_valid_d;
    logic [PAGE_W-1:0]   load_page_q, load_page_d;
    logic                load_start_q, load_start_d;
    logic [WORD_W-1:0]   cache_addr_q, cache_addr_d;
    logic                core_ack_q, core_ack_d;
    logic                core_err_q, core_err_d;
    logic [31:0]         core_data_q, core_data_d;
    logic                wb_ack_q, wb_ack_d;
    logic                wb_err_q, wb_err_d;
    logic [31:0]         wb_data_q, wb_data_d;
    logic                busy_q, busy_d;

    logic                  sel_wb_c;
    logic [ADDR_WIDTH-1:0] req_addr_c;
    logic [PAGE_W-1:0]     req_page_c;
    logic [WORD_W-1:0]     req_word_c;
    logic [31:0]           resp_data_c;
    logic                  unused_c;

    // Byte-lane bits are irrelevant for word reads.
    assign unused_c = ^{core_addr[1:0], wb_addr[1:0]};

    // Round-robin select: a lone requester wins; a tie goes to whoever did not win the last tie.
    assign sel_wb_c   = wb_req & (~core_req | (last_grant_q == GNT_CORE));
    assign req_addr_c = sel_wb_c ? wb_addr : core_addr;
    assign req_page_c = req_addr_c[ADDR_WIDTH-1:WORD_W+2];
    assign req_word_c = req_addr_c[WORD_W+1:2];
    assign resp_data_c = resp_err_q ? 32'hFFFF_FFFF : cache_rdata;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        resp_err_d   = resp_err_q;
        manual_d     = manual_q;
        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        req_word_d   = req_word_q;
        cur_page_d   = cur_page_q;
        page_valid_d = page_valid_q;
        load_page_d  = load_page_q;
        cache_addr_d = cache_addr_q;
        load_start_d = 1'b0;
        core_ack_d   = 1'b0;
        core_err_d   = 1'b0;
        core_data_d  = 32'h0;
        wb_ack_d     = 1'b0;
        wb_err_d     = 1'b0;
        wb_data_d    = 32'h0;

        // Page writes arriving mid-transaction are parked; the latest one wins.
        if (page_wr && (state_q != IDLE)) begin
            pend_d      = 1'b1;
            pend_data_d = page_wr_data;
        end

        case (state_q)
            IDLE: begin
                if (pend_q || page_wr) begin
                    cur_page_d   = page_wr ? page_wr_data : pend_data_q;
                    load_page_d  = page_wr ? page_wr_data : pend_data_q;
                    page_valid_d = 1'b0;
                    pend_d       = 1'b0;
                    manual_d     = 1'b1;
                    state_d      = LOAD_START;
                end else if (core_req || wb_req) begin
                    grant_d    = sel_wb_c;
                    manual_d   = 1'b0;
                    resp_err_d = 1'b0;
                    req_word_d = req_word_c;
                    if (core_req && wb_req) begin
                        last_grant_d = sel_wb_c;
                    end
                    if (!flash_enable) begin
                        resp_err_d = 1'b1;
                        state_d    = RESPOND;
                    end else if (page_valid_q && (req_page_c == cur_page_q)) begin
                        cache_addr_d = req_word_c;
                        state_d      = READ;
                    end else if (auto_page) begin
                        // SRAM contents are about to be overwritten.
                        load_page_d  = req_page_c;
                        page_valid_d = 1'b0;
                        state_d      = LOAD_START;
                    end else begin
                        resp_err_d = 1'b1;
                        state_d    = RESPOND;
                    end
                end
            end
            LOAD_START: begin
                load_start_d = 1'b1;
                state_d      = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (load_done) begin
                    cur_page_d   = load_page_q;
                    page_valid_d = 1'b1;
                    if (manual_q) begin
                        state_d = IDLE;
                    end else begin
                        cache_addr_d = req_word_q;
                        state_d      = READ;
                    end
                end
            end
            READ: begin
                state_d = RESPOND;
            end
            RESPOND: begin
                if (grant_q == GNT_WB) begin
                    wb_ack_d  = 1'b1;
                    wb_err_d  = resp_err_q;
                    wb_data_d = resp_data_c;
                end else begin
                    core_ack_d  = 1'b1;
                    core_err_d  = resp_err_q;
                    core_data_d = resp_data_c;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_CORE;
            last_grant_q <= GNT_WB;
            resp_err_q   <= 1'b0;
            manual_q     <= 1'b0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            req_word_q   <= '0;
            cur_page_q   <= '0;
            page_valid_q <= 1'b0;
            load_page_q  <= '0;
            load_start_q <= 1'b0;
            cache_addr_q <= '0;
            core_ack_q   <= 1'b0;
            core_err_q   <= 1'b0;
            core_data_q  <= 32'h0;
            wb_ack_q     <= 1'b0;
            wb_err_q     <= 1'b0;
            wb_data_q    <= 32'h0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            resp_err_q   <= resp_err_d;
            manual_q     <= manual_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            req_word_q   <= req_word_d;
            cur_page_q   <= cur_page_d;
            page_valid_q <= page_valid_d;
            load_page_q  <= load_page_d;
            load_start_q <= load_start_d;
            cache_addr_q <= cache_addr_d;
            core_ack_q   <= core_ack_d;
            core_err_q   <= core_err_d;
            core_data_q  <= core_data_d;
            wb_ack_q     <= wb_ack_d;
            wb_err_q     <= wb_err_d;
            wb_data_q    <= wb_data_d;
            busy_q       <= busy_d;
        end
    end

    assign core_ack     = core_ack_q;
    assign core_err     = core_err_q;
    assign core_data    = core_data_q;
    assign wb_ack       = wb_ack_q;
    assign wb_err       = wb_err_q;
    assign wb_data      = wb_data_q;
    assign cache_addr   = cache_addr_q;
    assign load_start   = load_start_q;
    assign load_page    = load_page_q;
    assign current_page = cur_page_q;
    assign page_valid   = page_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_flash_cache_arbiter.sv
// Testbench for flash_cache_arbiter: page-SRAM and loader models, response
// scoreboard (expected pushed on request, compared as acks are observed).
module tb_flash_cache_arbiter;

    localparam int LOAD_LAT = 5;

    typedef struct {
        bit          port;   // 0 = core, 1 = wb
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flash_enable = 1'b0;
    logic        auto_page = 1'b0;
    logic        page_wr = 1'b0;
    logic [12:0] page_wr_data = '0;
    logic        core_req = 1'b0;
    logic [23:0] core_addr = '0;
    logic        core_ack, core_err;
    logic [31:0] core_data;
    logic        wb_req = 1'b0;
    logic [23:0] wb_addr = '0;
    logic        wb_ack, wb_err;
    logic [31:0] wb_data;
    logic [8:0]  cache_addr;
    logic [31:0] cache_rdata = '0;
    logic        load_start;
    logic [12:0] load_page;
    logic        load_done = 1'b0;
    logic [12:0] current_page;
    logic        page_valid;
    logic        busy;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          ls_cnt = 0;
    int          ls_cyc = 0;
    logic [12:0] ls_page = '0;
    int          done_cyc = 0;
    int          dual_ack = 0;
    resp_t       exp_q[$];
    resp_t       obs_q[$];

    logic [12:0] loaded_page = '0;
    int          ld_cnt = 0;

    flash_cache_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .flash_enable (flash_enable),
        .auto_page    (auto_page),
        .page_wr      (page_wr),
        .page_wr_data (page_wr_data),
        .core_req     (core_req),
        .core_addr    (core_addr),
        .core_ack     (core_ack),
        .core_err     (core_err),
        .core_data    (core_data),
        .wb_req       (wb_req),
        .wb_addr      (wb_addr),
        .wb_ack       (wb_ack),
        .wb_err       (wb_err),
        .wb_data      (wb_data),
        .cache_addr   (cache_addr),
        .cache_rdata  (cache_rdata),
        .load_start   (load_start),
        .load_page    (load_page),
        .load_done    (load_done),
        .current_page (current_page),
        .page_valid   (page_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM word contents encode which page is loaded and which word is read.
    function automatic logic [31:0] sram_word(input logic [12:0] page, input logic [8:0] word);
        return {3'b000, page, 7'b0, word};
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] addr);
        return sram_word(addr[23:11], addr[10:2]);
    endfunction

    always @(posedge clk) cache_rdata <= sram_word(loaded_page, cache_addr);

    // Loader model: fixed latency after load_start, reset with the arbiter.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt    <= 0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_start) begin
                ld_cnt <= LOAD_LAT;
            end else if (ld_cnt == 1) begin
                load_done   <= 1'b1;
                loaded_page <= load_page;
                ld_cnt      <= 0;
            end else if (ld_cnt > 1) begin
                ld_cnt <= ld_cnt - 1;
            end
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        resp_t o;
        if (core_ack === 1'b1) begin
            o.port = 1'b0; o.err = core_err; o.data = core_data;
            obs_q.push_back(o);
        end
        if (wb_ack === 1'b1) begin
            o.port = 1'b1; o.err = wb_err; o.data = wb_data;
            obs_q.push_back(o);
        end
        if (core_ack === 1'b1 && wb_ack === 1'b1) dual_ack++;
        if (load_start === 1'b1) begin
            ls_cnt++;
            ls_page = load_page;
            ls_cyc  = cyc;
        end
        if (load_done) done_cyc = cyc;
    end

    // Drive one read on a port and hold it until ack; reports request and ack cycles.
    task automatic read_req(input bit port, input logic [23:0] addr,
                            output int raise_cyc, output int ack_cyc);
        bit seen = 1'b0;
        @(posedge clk); #1;
        if (port) begin wb_req = 1'b1; wb_addr = addr; end
        else begin core_req = 1'b1; core_addr = addr; end
        raise_cyc = cyc;
        ack_cyc = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if ((port ? wb_ack : core_ack) === 1'b1) begin
                seen = 1'b1;
                ack_cyc = cyc;
            end
        end
        if (port) wb_req = 1'b0; else core_req = 1'b0;
        n_checks++;
        if (!seen) $display("FAIL ack_timeout port %0d addr %h: got no ack, required ack within 200 cycles", port, addr);
        else n_pass++;
        #1;
    endtask

    task automatic push_exp(input bit port, input logic err, input logic [31:0] data);
        resp_t e;
        e.port = port; e.err = err; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        resp_t e, o;
        bit seen = 1'b0;
        rst = 1'b0; flash_enable = 1'b1; auto_page = 1'b1;
        core_req = 1'b1; core_addr = 24'h003010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({core_ack, core_err, core_data, wb_ack, wb_err, wb_data, cache_addr, load_start,
             load_page, current_page, page_valid, busy} !== '0)
            $display("FAIL reset_outputs: got %h required all zero",
                     {core_ack, core_err, core_data, wb_ack, wb_err, wb_data, cache_addr,
                      load_start, load_page, current_page, page_valid, busy});
        else n_pass++;
        n_checks++;
        if (ls_cnt !== 0) $display("FAIL reset_no_load: got %0d load_start pulses required 0", ls_cnt);
        else n_pass++;
        rst = 1'b1;
        push_exp(1'b0, 1'b0, exp_word(24'h003010));
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (core_ack === 1'b1) seen = 1'b1;
        end
        core_req = 1'b0;
        #1;
        n_checks++;
        if (ls_cnt !== 1 || ls_page !== 13'd6)
            $display("FAIL reset_first_load: got %0d loads page %0d required 1 load page 6", ls_cnt, ls_page);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL reset_resp: got no response required port %0d err %0d data %h", e.port, e.err, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.port !== e.port || o.err !== e.err || o.data !== e.data)
                    $display("FAIL reset_resp: got port %0d err %0d data %h required port %0d err %0d data %h",
                             o.port, o.err, o.data, e.port, e.err, e.data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_miss_then_hit();
        resp_t e, o;
        int raise, ackc, ls0;
        ls0 = ls_cnt;
        push_exp(1'b0, 1'b0, exp_word(24'h000804));
        read_req(1'b0, 24'h000804, raise, ackc);
        n_checks++;
        if (ls_cnt !== ls0 + 1 || ls_page !== 13'd1)
            $display("FAIL miss_load: got %0d loads page %0d required 1 load page 1", ls_cnt - ls0, ls_page);
        else n_pass++;
        n_checks++;
        if (ls_cyc - raise !== 2) $display("FAIL miss_load_start_time: got %0d cycles required 2", ls_cyc - raise);
        else n_pass++;
        n_checks++;
        if (ackc - done_cyc !== 3) $display("FAIL miss_ack_after_done: got %0d cycles required 3", ackc - done_cyc);
        else n_pass++;
        n_checks++;
        if (cache_addr !== 9'd1) $display("FAIL miss_cache_addr: got %0d required 1", cache_addr);
        else n_pass++;
        ls0 = ls_cnt;
        push_exp(1'b0, 1'b0, exp_word(24'h000808));
        read_req(1'b0, 24'h000808, raise, ackc);
        n_checks++;
        if (ackc - raise !== 3) $display("FAIL hit_latency: got %0d cycles required 3", ackc - raise);
        else n_pass++;
        n_checks++;
        if (ls_cnt !== ls0) $display("FAIL hit_no_load: got %0d loads required 0", ls_cnt - ls0);
        else n_pass++;
        n_checks++;
        if (current_page !== 13'd1 || page_valid !== 1'b1)
            $display("FAIL hit_page_state: got page %0d valid %0d required page 1 valid 1", current_page, page_valid);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL miss_hit_resp: got no response required port %0d err %0d data %h", e.port, e.err, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.port !== e.port || o.err !== e.err || o.data !== e.data)
                    $display("FAIL miss_hit_resp: got port %0d err %0d data %h required port %0d err %0d data %h",
                             o.port, o.err, o.data, e.port, e.err, e.data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_contention();
        resp_t e, o;
        int rc, ac, rw, aw;
        logic [23:0] ca, wa;
        // First tie goes to the core, then ties alternate WB, core, WB.
        for (int r = 0; r < 4; r++) begin
            ca = 24'h000810 + 24'(r * 4);
            wa = 24'h000C00 + 24'(r * 4);
            if (r == 0 || r == 2) begin
                push_exp(1'b0, 1'b0, exp_word(ca));
                push_exp(1'b1, 1'b0, exp_word(wa));
            end else begin
                push_exp(1'b1, 1'b0, exp_word(wa));
                push_exp(1'b0, 1'b0, exp_word(ca));
            end
            fork
                read_req(1'b0, ca, rc, ac);
                read_req(1'b1, wa, rw, aw);
            join
            n_checks++;
            if (((r == 0 || r == 2) ? (ac - rc) : (aw - rw)) !== 3)
                $display("FAIL tie%0d_first_latency: got %0d cycles required 3", r,
                         (r == 0 || r == 2) ? (ac - rc) : (aw - rw));
            else n_pass++;
            n_checks++;
            if (((r == 0 || r == 2) ? (aw - ac) : (ac - aw)) !== 3)
                $display("FAIL tie%0d_second_gap: got %0d cycles required 3", r,
                         (r == 0 || r == 2) ? (aw - ac) : (ac - aw));
            else n_pass++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL tie_resp: got no response required port %0d err %0d data %h", e.port, e.err, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.port !== e.port || o.err !== e.err || o.data !== e.data)
                    $display("FAIL tie_resp: got port %0d err %0d data %h required port %0d err %0d data %h",
                             o.port, o.err, o.data, e.port, e.err, e.data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_auto_disabled_miss();
        resp_t e, o;
        int raise, ackc, ls0;
        bit idle = 1'b0;
        auto_page = 1'b0;
        @(posedge clk); #1;
        page_wr = 1'b1; page_wr_data = 13'd0;
        @(posedge clk); #1;
        page_wr = 1'b0;
        for (int i = 0; i < 50 && !idle; i++) begin
            @(negedge clk);
            if (page_valid === 1'b1 && busy === 1'b0) idle = 1'b1;
        end
        n_checks++;
        if (!idle || current_page !== 13'd0)
            $display("FAIL manual_page0: got page %0d valid %0d required page 0 valid 1", current_page, page_valid);
        else n_pass++;
        ls0 = ls_cnt;
        push_exp(1'b1, 1'b1, 32'hFFFF_FFFF);
        read_req(1'b1, 24'h001000, raise, ackc);
        n_checks++;
        if (ackc - raise !== 2) $display("FAIL nauto_latency: got %0d cycles required 2", ackc - raise);
        else n_pass++;
        n_checks++;
        if (ls_cnt !== ls0) $display("FAIL nauto_no_load: got %0d loads required 0", ls_cnt - ls0);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL nauto_resp: got no response required port %0d err %0d data %h", e.port, e.err, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.port !== e.port || o.err !== e.err || o.data !== e.data)
                    $display("FAIL nauto_resp: got port %0d err %0d data %h required port %0d err %0d data %h",
                             o.port, o.err, o.data, e.port, e.err, e.data);
                else n_pass++;
            end
        end
        auto_page = 1'b1;
    endtask

    task automatic test_page_wr_during_load();
        resp_t e, o;
        int raise, ackc, ls0, bad;
        bit seen;
        ls0 = ls_cnt;
        push_exp(1'b0, 1'b0, exp_word(24'h001008));
        fork
            read_req(1'b0, 24'h001008, raise, ackc);
            begin
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (load_start === 1'b1) seen = 1'b1;
                end
                // Two writes while the page-2 load is in flight; the second must win.
                @(posedge clk); #1;
                page_wr = 1'b1; page_wr_data = 13'd4;
                @(posedge clk); #1;
                page_wr_data = 13'd5;
                @(posedge clk); #1;
                page_wr = 1'b0;
            end
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL pagewr_resp: got no response required port %0d err %0d data %h", e.port, e.err, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.port !== e.port || o.err !== e.err || o.data !== e.data)
                    $display("FAIL pagewr_resp: got port %0d err %0d data %h required port %0d err %0d data %h",
                             o.port, o.err, o.data, e.port, e.err, e.data);
                else n_pass++;
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (load_start === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || load_page !== 13'd5 || current_page !== 13'd5)
            $display("FAIL pagewr_reload: got start %0d load_page %0d current_page %0d required 1 5 5",
                     seen, load_page, current_page);
        else n_pass++;
        bad = 0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (page_valid !== 1'b0 || busy !== 1'b1) bad++;
            if (load_done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen || bad !== 0)
            $display("FAIL pagewr_during_reload: got done %0d with %0d bad cycles required done with 0 (valid 0 busy 1)",
                     seen, bad);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (page_valid !== 1'b1 || busy !== 1'b0 || current_page !== 13'd5)
            $display("FAIL pagewr_after_done: got valid %0d busy %0d page %0d required 1 0 5",
                     page_valid, busy, current_page);
        else n_pass++;
        n_checks++;
        if (ls_cnt - ls0 !== 2) $display("FAIL pagewr_load_count: got %0d loads required 2", ls_cnt - ls0);
        else n_pass++;
    endtask

    task automatic test_flash_disabled();
        resp_t e, o;
        int raise, ackc, ls0;
        logic [8:0] ca0;
        flash_enable = 1'b0;
        ls0 = ls_cnt;
        ca0 = cache_addr;
        push_exp(1'b0, 1'b1, 32'hFFFF_FFFF);
        read_req(1'b0, 24'h004000, raise, ackc);
        n_checks++;
        if (ackc - raise !== 2) $display("FAIL fdis_latency: got %0d cycles required 2", ackc - raise);
        else n_pass++;
        n_checks++;
        if (ls_cnt !== ls0 || cache_addr !== ca0)
            $display("FAIL fdis_no_activity: got %0d loads cache_addr %0d required 0 loads cache_addr %0d",
                     ls_cnt - ls0, cache_addr, ca0);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0)
                $display("FAIL fdis_resp: got no response required port %0d err %0d data %h", e.port, e.err, e.data);
            else begin
                o = obs_q.pop_front();
                if (o.port !== e.port || o.err !== e.err || o.data !== e.data)
                    $display("FAIL fdis_resp: got port %0d err %0d data %h required port %0d err %0d data %h",
                             o.port, o.err, o.data, e.port, e.err, e.data);
                else n_pass++;
            end
        end
        flash_enable = 1'b1;
    endtask

    task automatic test_reset_mid_load();
        bit seen = 1'b0;
        @(posedge clk); #1;
        core_req = 1'b1; core_addr = 24'h004800;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (load_start === 1'b1) seen = 1'b1;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (!seen || load_start !== 1'b0 || page_valid !== 1'b0 || busy !== 1'b0 || current_page !== 13'd0)
            $display("FAIL rst_mid_load: got start_seen %0d load_start %0d valid %0d busy %0d page %0d required 1 0 0 0 0",
                     seen, load_start, page_valid, busy, current_page);
        else n_pass++;
        core_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 0 || busy !== 1'b0)
            $display("FAIL rst_mid_load_quiet: got %0d stray acks busy %0d required 0 0", obs_q.size(), busy);
        else n_pass++;
        n_checks++;
        if (dual_ack !== 0) $display("FAIL dual_ack: got %0d cycles with both acks required 0", dual_ack);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_contention();
        test_auto_disabled_miss();
        test_page_wr_during_load();
        test_flash_disabled();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
